// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared FSM encoding and widths for the shift-add multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int OPW      = 8;
    localparam int PRODW    = 16;
    localparam int MUL_ITER = 8;
    localparam int CNTW     = 3;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MUL_ITER - 1);

    // 2'd3 is unused and falls back to S_IDLE on the next edge
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adder_cout.sv
// ============================================================================
// adder_cout : 8-bit ripple-carry adder with carry-out, built from full_adder
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_cout
    import mult_pkg::*;
(
    input  logic [OPW-1:0] op1,
    input  logic [OPW-1:0] op2,
    input  logic           cin,
    output logic [OPW-1:0] sum,
    output logic           cout
);

    logic [OPW:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[OPW];

    for (genvar i = 0; i < OPW; i++) begin : g_bit
        full_adder u_fa (
            .a  (op1[i]),
            .b  (op2[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// shift_add_multiplier : 8x8 unsigned multi-cycle multiplier, one add-shift
// iteration per cycle through a shared ripple adder.  Rev 1.0
// ============================================================================
`default_nettype none

module shift_add_multiplier
    import mult_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [OPW-1:0]   MCAND,
    input  logic [OPW-1:0]   MPLIER,
    output logic             BUSY,
    output logic             DONE,
    output logic [PRODW-1:0] PRODUCT,
    output logic             OVERFLOW
);

    state_t          state, state_next;
    logic [OPW-1:0]  m, a, q;
    logic [CNTW-1:0] cnt;
    logic [PRODW-1:0] product;
    logic            overflow;

    logic [OPW-1:0]  add_b, sum, a_shift, q_shift;
    logic            cout, accept, last_iter;

    assign add_b = q[0] ? m : '0;

    adder_cout u_adder (
        .op1  (a),
        .op2  (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // {C,A',Q} shifted right by one: carry drops into A[7], A'[0] into Q[7]
    assign a_shift   = {cout, sum[OPW-1:1]};
    assign q_shift   = {sum[0], q[OPW-1:1]};
    assign accept    = START && ((state == S_IDLE) || (state == S_DONE));
    assign last_iter = (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = START ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_iter ? S_DONE : S_RUN;
            S_DONE:  state_next = START ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            m        <= '0;
            a        <= '0;
            q        <= '0;
            cnt      <= '0;
            product  <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            m   <= MCAND;
            q   <= MPLIER;
            a   <= '0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            a   <= a_shift;
            q   <= q_shift;
            cnt <= cnt + CNTW'(1);
            if (last_iter) begin
                product  <= {a_shift, q_shift};
                overflow <= (a_shift != '0);
            end
        end
    end

    assign BUSY     = (state == S_RUN);
    assign DONE     = (state == S_DONE);
    assign PRODUCT  = product;
    assign OVERFLOW = overflow;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// tb_shift_add_multiplier : directed self-checking bench for the multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [7:0]  MCAND, MPLIER;
    logic        BUSY, DONE, OVERFLOW;
    logic [15:0] PRODUCT;

    int total = 0;
    int bad   = 0;
    logic [15:0] held_prod = 16'h0000;

    shift_add_multiplier dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .MCAND    (MCAND),
        .MPLIER   (MPLIER),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PRODUCT  (PRODUCT),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept edge, 8 iterations, DONE cycle; checks handshake and the held result.
    task automatic run_mul(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                           input logic [15:0] exp_p, input logic exp_ov);
        START = 1'b1; MCAND = mc; MPLIER = mp;
        step();
        START = 1'b0; MCAND = 8'hA5; MPLIER = 8'h5A;
        chk({tag, "_busy0"}, {31'd0, BUSY}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk({tag, "_busy"}, {30'd0, BUSY, DONE}, 32'd2);
            chk({tag, "_held"}, {16'd0, PRODUCT}, {16'd0, held_prod});
        end
        step();
        chk({tag, "_done"}, {30'd0, BUSY, DONE}, 32'd1);
        chk({tag, "_prod"}, {16'd0, PRODUCT}, {16'd0, exp_p});
        chk({tag, "_ovf"},  {31'd0, OVERFLOW}, {31'd0, exp_ov});
        held_prod = exp_p;
        step();
        chk({tag, "_idle"}, {30'd0, BUSY, DONE}, 32'd0);
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; MCAND = 8'd0; MPLIER = 8'd0;
        step();
        step();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_prod", {16'd0, PRODUCT}, 32'd0);
        chk("rst_ovf",  {31'd0, OVERFLOW}, 32'd0);
        RESET_N = 1'b1;
        step();

        run_mul("basic", 8'd13, 8'd11, 16'h008F, 1'b0);
        run_mul("max",   8'd255, 8'd255, 16'hFE01, 1'b1);
        run_mul("zero_a", 8'd0, 8'd200, 16'h0000, 1'b0);
        run_mul("zero_b", 8'd200, 8'd0, 16'h0000, 1'b0);
        run_mul("one",   8'd1, 8'd255, 16'h00FF, 1'b0);

        // START pulsed mid-RUN must be ignored
        START = 1'b1; MCAND = 8'd7; MPLIER = 8'd9;
        step();
        START = 1'b0;
        step(); step(); step();
        START = 1'b1; MCAND = 8'd3; MPLIER = 8'd3;
        step();
        START = 1'b0;
        chk("ign_busy", {31'd0, BUSY}, 32'd1);
        step(); step(); step();
        chk("ign_busy7", {30'd0, BUSY, DONE}, 32'd2);
        step();
        chk("ign_done", {30'd0, BUSY, DONE}, 32'd1);
        chk("ign_prod", {16'd0, PRODUCT}, 32'd63);
        held_prod = 16'd63;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ign_nodone", {30'd0, BUSY, DONE}, 32'd0);
        end

        // reset mid-operation discards the run and clears the result
        START = 1'b1; MCAND = 8'd100; MPLIER = 8'd3;
        step();
        START = 1'b0;
        step(); step(); step(); step();
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        chk("mrst_busy", {31'd0, BUSY}, 32'd0);
        chk("mrst_done", {31'd0, DONE}, 32'd0);
        chk("mrst_prod", {16'd0, PRODUCT}, 32'd0);
        chk("mrst_ovf",  {31'd0, OVERFLOW}, 32'd0);
        held_prod = 16'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mrst_quiet", {30'd0, BUSY, DONE}, 32'd0);
        end
        run_mul("after_rst", 8'd5, 8'd5, 16'd25, 1'b0);

        // back-to-back with START held high
        START = 1'b1; MCAND = 8'd16; MPLIER = 8'd16;
        step();
        for (int i = 1; i < 8; i++) begin
            step();
            chk("b2b_busy1", {30'd0, BUSY, DONE}, 32'd2);
        end
        step();
        chk("b2b_done1", {30'd0, BUSY, DONE}, 32'd1);
        chk("b2b_prod1", {16'd0, PRODUCT}, 32'd256);
        chk("b2b_ovf1",  {31'd0, OVERFLOW}, 32'd1);
        MCAND = 8'd2; MPLIER = 8'd128;
        step();
        chk("b2b_rerun", {30'd0, BUSY, DONE}, 32'd2);
        chk("b2b_hold",  {16'd0, PRODUCT}, 32'd256);
        MCAND = 8'd0; MPLIER = 8'd0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("b2b_busy2", {30'd0, BUSY, DONE}, 32'd2);
        end
        step();
        START = 1'b0;
        chk("b2b_done2", {30'd0, BUSY, DONE}, 32'd1);
        chk("b2b_prod2", {16'd0, PRODUCT}, 32'd256);
        chk("b2b_ovf2",  {31'd0, OVERFLOW}, 32'd1);
        step();
        chk("b2b_end", {30'd0, BUSY, DONE}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
